// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port arbiter/sequencer in front of the shared memory, with tagged read return.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module memory_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_rw0,
  input  logic              i_rw1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_cs,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  logic              w_sel1, w_gnt0, w_gnt1, w_gnt, w_rw, w_ret0, w_ret1;
  logic              r_cs, r_rw, r_rvalid0, r_rvalid1;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [MEM_LAT:0]  r_tag_v, r_tag_p;
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_sel1 = i_req1 & (~i_req0 | ~r_last);
  always_ff @(posedge i_clk)
    if (i_rst) r_last <= 1'b1;
    else if (w_gnt) r_last <= w_gnt1;
`else
  assign w_sel1 = i_req1 & ~i_req0;
`endif
  assign w_gnt1 = ~i_rst & w_sel1;
  assign w_gnt0 = ~i_rst & i_req0 & ~w_sel1;
  assign w_gnt  = w_gnt0 | w_gnt1;
  assign w_rw   = w_gnt1 ? i_rw1 : i_rw0;
  assign w_ret0 = r_tag_v[MEM_LAT] & ~r_tag_p[MEM_LAT];
  assign w_ret1 = r_tag_v[MEM_LAT] & r_tag_p[MEM_LAT];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs      <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tag_v   <= '0;
      r_tag_p   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_cs      <= w_gnt;
      r_tag_v   <= {r_tag_v[MEM_LAT-1:0], w_gnt & ~w_rw};
      r_tag_p   <= {r_tag_p[MEM_LAT-1:0], w_gnt1};
      r_rvalid0 <= w_ret0;
      r_rvalid1 <= w_ret1;
      if (w_gnt) begin
        r_rw    <= w_rw;
        r_addr  <= w_gnt1 ? i_addr1 : i_addr0;
        r_wdata <= w_gnt1 ? i_wdata1 : i_wdata0;
      end
      if (w_ret0) r_rdata0 <= i_mem_rdata;
      if (w_ret1) r_rdata1 <= i_mem_rdata;
    end
  end
  // a write whose issue cycle meets reset must never reach the memory
  assign o_mem_cs    = r_cs & ~i_rst;
  assign o_mem_rw    = r_rw;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_rvalid0   = r_rvalid0;
  assign o_rvalid1   = r_rvalid1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven check of memory_arbiter against a 1-cycle-latency memory model
// preloaded with mem[a] = 0x1000 + a; expectations adapt to ARB_ROUND_ROBIN_EN.
module tb_memory_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [15:0] BF = 16'hBEEF;
  logic clk = 1'b0;
  logic rst, req0, req1, rw0, rw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_cs, mem_rw;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] wr [int];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  memory_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_rw0(rw0), .i_rw1(rw1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_mem_cs(mem_cs), .o_mem_rw(mem_rw),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_rw) wr[int'(mem_addr[11:0])] = mem_wdata;
      else mem_rdata <= wr.exists(int'(mem_addr[11:0])) ? wr[int'(mem_addr[11:0])] : 16'h1000 + {4'h0, mem_addr[11:0]};
    end
  typedef struct packed {
    logic rst, q0, w0;
    logic [15:0] a0, d0;
    logic q1, w1;
    logic [15:0] a1;
    logic g0, g1, cs, mrw;
    logic [15:0] maddr, md;
    logic v0;
    logic [15:0] r0;
    logic v1;
    logic [15:0] r1;
  } vec_t;
  vec_t t[$];
  function automatic vec_t vr(input logic rst_, q0, w0, input logic [15:0] a0, d0, input logic q1, w1,
                              input logic [15:0] a1, input logic g0, g1, cs, mrw, input logic [15:0] maddr, md,
                              input logic v0, input logic [15:0] r0, input logic v1, input logic [15:0] r1);
    return '{rst_, q0, w0, a0, d0, q1, w1, a1, g0, g1, cs, mrw, maddr, md, v0, r0, v1, r1};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  initial begin
    bit ok;
    int lat;
    logic [15:0] r1_prev;
    // reset row: a request during reset must not be granted
    t.push_back(vr(1, 1, 0, 16'h055, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // write 0xBEEF to 0x010 then read it back
    t.push_back(vr(0, 1, 1, 16'h010, BF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 1, 0, 16'h010, 0, 0, 0, 0, 1, 0, 1, 1, 16'h010, BF, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h010, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BF, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BF, 0, 0));
    // port1 streams reads of 0x000..0x007
    for (int j = 0; j < 12; j++)
      t.push_back(vr(0, 0, 0, 0, 0, j < 8, 0, 16'(j), j < 8 ? 1'b0 : 1'b0, j < 8, j >= 1 && j <= 8, 0, 16'(j - 1), 0,
                     0, BF, j >= 3 && j <= 10, j >= 3 ? 16'h1000 + 16'(j > 10 ? 7 : j - 3) : 16'h0));
    // contention: both ports hold read requests for 6 cycles
    for (int j = 0; j < 10; j++)
      t.push_back(vr(0, j < 6, 0, 16'h020, 0, j < 6, 0, 16'h030,
                     j < 6 && !(RR && j % 2 == 1), j < 6 && RR && j % 2 == 1,
                     j >= 1 && j <= 6, 0, (RR && (j - 1) % 2 == 1) ? 16'h030 : 16'h020, 0,
                     j >= 3 && j <= 8 && !(RR && (j - 3) % 2 == 1), j >= 3 ? 16'h1020 : BF,
                     j >= 3 && j <= 8 && RR && (j - 3) % 2 == 1, (RR && j >= 4) ? 16'h1030 : 16'h1007));
    // interleaved reads port0 0x100 / port1 0x200
    r1_prev = RR ? 16'h1030 : 16'h1007;
    for (int j = 0; j < 8; j++)
      t.push_back(vr(0, j < 4 && j % 2 == 0, 0, 16'h100, 0, j < 4 && j % 2 == 1, 0, 16'h200,
                     j < 4 && j % 2 == 0, j < 4 && j % 2 == 1, j >= 1 && j <= 4, 0,
                     (j - 1) % 2 == 0 ? 16'h100 : 16'h200, 0,
                     j == 3 || j == 5, j >= 3 ? 16'h1100 : 16'h1020, j == 4 || j == 6, j >= 4 ? 16'h1200 : r1_prev));
    // port1 request withdrawn while port0 wins
    for (int j = 0; j < 5; j++)
      t.push_back(vr(0, j == 0, 0, 16'h040, 0, j == 0, 0, 16'h050, j == 0, 0, j == 1, 0, 16'h040, 0,
                     j == 3, j >= 3 ? 16'h1040 : 16'h1100, 0, 16'h1200));
    // reset one cycle after two read grants
    t.push_back(vr(0, 1, 0, 16'h060, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h1040, 0, 16'h1200));
    t.push_back(vr(0, 0, 0, 0, 0, 1, 0, 16'h070, 0, 1, 1, 0, 16'h060, 0, 0, 16'h1040, 0, 16'h1200));
    t.push_back(vr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1040, 0, 16'h1200));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 1, 0, 16'h080, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h080, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1080));
    t.push_back(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1080));
    {rst, req0, req1, rw0, rw1} = 5'b10000;
    {addr0, addr1, wdata0, wdata1} = '0;
    repeat (2) @(posedge clk);
    foreach (t[i]) begin
      @(negedge clk);
      {rst, req0, rw0, addr0, wdata0, req1, rw1, addr1} = {t[i].rst, t[i].q0, t[i].w0, t[i].a0, t[i].d0, t[i].q1, t[i].w1, t[i].a1};
      #1;
      ok = gnt0 === t[i].g0 && gnt1 === t[i].g1 && mem_cs === t[i].cs &&
           (!t[i].cs || (mem_rw === t[i].mrw && mem_addr === t[i].maddr && (!t[i].mrw || mem_wdata === t[i].md))) &&
           rvalid0 === t[i].v0 && rdata0 === t[i].r0 && rvalid1 === t[i].v1 && rdata1 === t[i].r1;
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL row %0d: got gnt=%b%b cs=%b rw=%b addr=%h wd=%h rv=%b%b rd0=%h rd1=%h; expected gnt=%b%b cs=%b rw=%b addr=%h wd=%h rv=%b%b rd0=%h rd1=%h",
                 i, gnt0, gnt1, mem_cs, mem_rw, mem_addr, mem_wdata, rvalid0, rvalid1, rdata0, rdata1,
                 t[i].g0, t[i].g1, t[i].cs, t[i].mrw, t[i].maddr, t[i].md, t[i].v0, t[i].v1, t[i].r0, t[i].r1);
      end
    end
    // write whose issue cycle coincides with reset must be dropped
    @(negedge clk);
    {rst, req1, req0, rw0, addr0, wdata0} = {3'b001, 1'b1, 16'h090, 16'h1234};
    #1 chk("wr_gnt", {31'h0, gnt0}, 1);
    @(negedge clk);
    {rst, req0, rw0} = 3'b100;
    #1 chk("wr_rst_cs", {31'h0, mem_cs}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_addr", {16'h0, mem_addr}, 0);
    chk("rst_rw", {31'h0, mem_rw}, 0);
    chk("rst_wdata", {16'h0, mem_wdata}, 0);
    @(negedge clk);
    {req0, rw0, addr0} = {2'b10, 16'h090};
    #1 chk("rd_gnt", {31'h0, gnt0}, 1);
    lat = 0;
    do begin
      @(negedge clk);
      req0 = 1'b0;
      lat++;
    end while (!rvalid0 && lat < 10);
    chk("rd_latency", lat, 3);
    chk("rd_dropped_write", {16'h0, rdata0}, 32'h1090);
    @(negedge clk);
    chk("rd_pulse", {31'h0, rvalid0}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
